// File: rtl/lotr_c2f_pkg.sv
// rtl/lotr_c2f_pkg.sv - shared C2F opcodes, response entry type and constants
package lotr_c2f_pkg;

    typedef enum logic [1:0] {
        RD     = 2'b00,
        WR     = 2'b01,
        RD_RSP = 2'b10,
        WR_RSP = 2'b11
    } c2f_op_e;

    typedef struct packed {
        c2f_op_e     opcode;
        logic [1:0]  thread;
        logic [31:0] data;
    } rsp_entry_t;

    localparam logic [31:0] BAD_ADDR_DATA = 32'hDEAD_BEEF;
    localparam logic [15:0] LFSR_SEED     = 16'hACE1;
    localparam int          RSP_ENTRY_W   = $bits(rsp_entry_t);

    // x^16 + x^14 + x^13 + x^11 + 1, shifting towards the MSB
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/c2f_rsp_fifo.sv
// rtl/c2f_rsp_fifo.sv - synchronous response FIFO with occupancy count
module c2f_rsp_fifo #(
    parameter int WIDTH = 38,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = store[rd_ptr];

    // a pop in the same cycle frees the slot a push at full needs
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/c2f_fabric_responder.sv
// rtl/c2f_fabric_responder.sv - C2F fabric endpoint with local memory; C2F_RSP_JITTER_EN adds randomised response delay
module c2f_fabric_responder
    import lotr_c2f_pkg::*;
#(
    parameter int          MEM_WORDS      = 1024,
    parameter logic [31:0] BASE_ADDR      = 32'h0040_0000,
    parameter int          RSP_FIFO_DEPTH = 8
) (
    input  logic        QClk,
    input  logic        RstQnnnL,
    input  logic        C2F_ReqValidQ500H,
    input  logic [1:0]  C2F_ReqOpcodeQ500H,
    input  logic [1:0]  C2F_ReqThreadIDQ500H,
    input  logic [31:0] C2F_ReqAddressQ500H,
    input  logic [31:0] C2F_ReqDataQ500H,
    output logic        C2F_RspValidQ502H,
    output logic [1:0]  C2F_RspOpcodeQ502H,
    output logic [1:0]  C2F_RspThreadIDQ502H,
    output logic [31:0] C2F_RspDataQ502H,
    output logic        C2F_RspStall,
    output logic        ErrAddrStickyQ,
    output logic        ErrDropStickyQ
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    if (RSP_FIFO_DEPTH < 4) begin : g_depth_chk
        $error("RSP_FIFO_DEPTH must be at least 4");
    end

    logic [31:0]      mem [MEM_WORDS];
    logic [31:0]      addr_off;
    logic             addr_in_range;

    logic             req_valid_q;
    logic             req_wr_q;
    logic [1:0]       req_thread_q;
    logic [IDX_W-1:0] req_idx_q;
    logic             req_in_range_q;
    logic [31:0]      req_data_q;

    rsp_entry_t       rsp_q501;
    rsp_entry_t       out_rsp;
    logic             out_valid;
    logic             drop;
    logic             mem_we;

    rsp_entry_t       rsp_q502;
    logic             rsp_valid_q;
    logic             err_addr_q;

    assign addr_off      = C2F_ReqAddressQ500H - BASE_ADDR;
    assign addr_in_range = (C2F_ReqAddressQ500H >= BASE_ADDR) && ((addr_off >> 2) < 32'(MEM_WORDS));

    always_ff @(posedge QClk) begin
        if (!RstQnnnL) begin
            req_valid_q    <= 1'b0;
            req_wr_q       <= 1'b0;
            req_thread_q   <= '0;
            req_idx_q      <= '0;
            req_in_range_q <= 1'b0;
            req_data_q     <= '0;
        end else begin
            req_valid_q    <= C2F_ReqValidQ500H;
            req_wr_q       <= (C2F_ReqOpcodeQ500H == WR);
            req_thread_q   <= C2F_ReqThreadIDQ500H;
            req_idx_q      <= addr_off[IDX_W+1:2];
            req_in_range_q <= addr_in_range;
            req_data_q     <= C2F_ReqDataQ500H;
        end
    end

    // read is combinational so a write ending the previous Q501H is already visible
    always_comb begin
        rsp_q501.opcode = req_wr_q ? WR_RSP : RD_RSP;
        rsp_q501.thread = req_thread_q;
        rsp_q501.data   = req_wr_q ? req_data_q
                        : (req_in_range_q ? mem[req_idx_q] : BAD_ADDR_DATA);
    end

    assign mem_we = RstQnnnL && req_valid_q && req_wr_q && req_in_range_q && !drop;

    always_ff @(posedge QClk) begin
        if (mem_we) begin
            mem[req_idx_q] <= req_data_q;
        end
    end

    always_ff @(posedge QClk) begin
        if (!RstQnnnL) begin
            err_addr_q <= 1'b0;
        end else if (req_valid_q && !req_in_range_q) begin
            err_addr_q <= 1'b1;
        end
    end

`ifdef C2F_RSP_JITTER_EN
    logic [15:0]                          lfsr;
    logic [1:0]                           wait_cnt;
    logic                                 stall_q;
    logic                                 err_drop_q;
    logic                                 fifo_push;
    logic                                 fifo_pop;
    logic                                 fifo_full;
    logic                                 fifo_empty;
    logic                                 bypass;
    logic [RSP_ENTRY_W+1:0]               fifo_din;
    logic [RSP_ENTRY_W+1:0]               fifo_dout;
    logic [$clog2(RSP_FIFO_DEPTH+1)-1:0]  fifo_count;
    logic [1:0]                           head_delay;
    rsp_entry_t                           head_rsp;

    assign fifo_din               = {lfsr[1:0], rsp_q501};
    assign {head_delay, head_rsp} = fifo_dout;

    // a zero-delay result skips the FIFO when it is empty, keeping the 2-cycle minimum
    always_comb begin
        fifo_pop  = !fifo_empty && (head_delay == wait_cnt);
        bypass    = fifo_empty && req_valid_q && (lfsr[1:0] == 2'd0);
        fifo_push = req_valid_q && !bypass && (!fifo_full || fifo_pop);
        drop      = req_valid_q && !bypass && fifo_full && !fifo_pop;
        out_valid = fifo_pop || bypass;
        out_rsp   = fifo_pop ? head_rsp : rsp_q501;
    end

    c2f_rsp_fifo #(
        .WIDTH (RSP_ENTRY_W + 2),
        .DEPTH (RSP_FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk       (QClk),
        .resetn    (RstQnnnL),
        .push      (fifo_push),
        .push_data (fifo_din),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge QClk) begin
        if (!RstQnnnL) begin
            lfsr       <= LFSR_SEED;
            wait_cnt   <= '0;
            stall_q    <= 1'b0;
            err_drop_q <= 1'b0;
        end else begin
            lfsr <= lfsr_next(lfsr);
            // wait_cnt counts cycles the current head has spent at the head
            if (fifo_pop) begin
                wait_cnt <= '0;
            end else if (fifo_empty) begin
                wait_cnt <= fifo_push ? 2'd1 : 2'd0;
            end else begin
                wait_cnt <= wait_cnt + 2'd1;
            end
            stall_q <= (32'(fifo_count) + 32'(req_valid_q)) >= 32'(RSP_FIFO_DEPTH - 2);
            if (drop) begin
                err_drop_q <= 1'b1;
            end
        end
    end

    assign C2F_RspStall   = stall_q;
    assign ErrDropStickyQ = err_drop_q;
`else
    assign drop           = 1'b0;
    assign out_valid      = req_valid_q;
    assign out_rsp        = rsp_q501;
    assign C2F_RspStall   = 1'b0;
    assign ErrDropStickyQ = 1'b0;
`endif

    always_ff @(posedge QClk) begin
        if (!RstQnnnL) begin
            rsp_valid_q <= 1'b0;
            rsp_q502    <= '0;
        end else begin
            rsp_valid_q <= out_valid;
            rsp_q502    <= out_valid ? out_rsp : '0;
        end
    end

    assign C2F_RspValidQ502H    = rsp_valid_q;
    assign C2F_RspOpcodeQ502H   = rsp_q502.opcode;
    assign C2F_RspThreadIDQ502H = rsp_q502.thread;
    assign C2F_RspDataQ502H     = rsp_q502.data;
    assign ErrAddrStickyQ       = err_addr_q;

endmodule

// File: tb/tb_c2f_fabric_responder.sv
// tb/tb_c2f_fabric_responder.sv - scoreboard bench for c2f_fabric_responder (C2F_RSP_JITTER_EN aware)
module tb_c2f_fabric_responder;

    localparam int          MW   = 1024;
    localparam logic [31:0] BASE = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = '0;
    logic [1:0]  req_thr = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic        rsp_valid;
    logic [1:0]  rsp_op;
    logic [1:0]  rsp_thr;
    logic [31:0] rsp_data;
    logic        stall;
    logic        err_addr;
    logic        err_drop;

    c2f_fabric_responder #(
        .MEM_WORDS      (MW),
        .BASE_ADDR      (BASE),
        .RSP_FIFO_DEPTH (8)
    ) dut (
        .QClk                 (clk),
        .RstQnnnL             (rstn),
        .C2F_ReqValidQ500H    (req_valid),
        .C2F_ReqOpcodeQ500H   (req_op),
        .C2F_ReqThreadIDQ500H (req_thr),
        .C2F_ReqAddressQ500H  (req_addr),
        .C2F_ReqDataQ500H     (req_data),
        .C2F_RspValidQ502H    (rsp_valid),
        .C2F_RspOpcodeQ502H   (rsp_op),
        .C2F_RspThreadIDQ502H (rsp_thr),
        .C2F_RspDataQ502H     (rsp_data),
        .C2F_RspStall         (stall),
        .ErrAddrStickyQ       (err_addr),
        .ErrDropStickyQ       (err_drop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  thr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mm [int];
    int          vectors = 0;
    int          miscompares = 0;
    bit          err_exp = 1'b0;
    bit          stall_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: each request's response derives from the architectural memory image in issue order.
    // Issuing also releases reset, so a request can be presented in the release cycle.
    task automatic issue(input bit honor, input logic [1:0] op, input logic [1:0] thr,
                         input logic [31:0] addr, input logic [31:0] data);
        exp_t        e;
        logic [31:0] off;
        bit          inr;
        int          n;
        @(negedge clk);
        n = 0;
        while (honor && rstn && stall && n < 64) begin
            req_valid = 1'b0;
            @(negedge clk);
            n++;
        end
        if (n >= 64) chk("stall_release", stall, 0);
        rstn     = 1'b1;
        req_valid = 1'b1;
        req_op   = op;
        req_thr  = thr;
        req_addr = addr;
        req_data = data;
        off = addr - BASE;
        inr = (addr >= BASE) && ((off >> 2) < MW);
        e.op  = (op == 2'b01) ? 2'b11 : 2'b10;
        e.thr = thr;
        e.cyc = cyc;
        if (op == 2'b01) begin
            e.data = data;
            if (inr) mm[int'(off >> 2)] = data;
        end else begin
            e.data = inr ? mm[int'(off >> 2)] : 32'hDEAD_BEEF;
        end
        if (!inr) err_exp = 1'b1;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
    endtask

    task automatic do_reset(input bit keep_req);
        @(negedge clk);
        rstn      = 1'b0;
        req_valid = keep_req;
        sb.delete();
        err_exp   = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_data", rsp_data, 0);
        chk("rst_err_addr", err_addr, 0);
        chk("rst_stall", stall, 0);
        chk("rst_err_drop", err_drop, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        bit   due;
        if (stall) stall_seen = 1'b1;
        if (!rsp_valid) begin
            chk("idle_data", rsp_data, 0);
            chk("idle_op_thr", {rsp_op, rsp_thr}, 0);
        end
`ifdef C2F_RSP_JITTER_EN
        if (rsp_valid) begin
            while (sb.size() > 0 && !(sb[0].data === rsp_data && sb[0].thr === rsp_thr && sb[0].op === rsp_op))
                void'(sb.pop_front());
            chk("rsp_expected", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rsp_latency_min", 32'((cyc - e.cyc) >= 2), 1);
            end
        end
`else
        due = (sb.size() > 0) && ((cyc - sb[0].cyc) >= 2);
        chk("rsp_valid", rsp_valid, due);
        if (sb.size() > 0 && (rsp_valid || due)) begin
            e = sb.pop_front();
            if (rsp_valid) begin
                chk("rsp_opcode", rsp_op, e.op);
                chk("rsp_thread", rsp_thr, e.thr);
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_latency", 32'(cyc - e.cyc), 2);
            end
        end
        chk("stall_const", stall, 0);
        chk("drop_const", err_drop, 0);
`endif
    end

    initial begin
        int n;
        do_reset(1'b0);

        // single write, then write followed immediately by a read of the same word
        issue(1, 2'b01, 2'd2, 32'h0040_0010, 32'h1234_5678);
        idle(3);
        issue(1, 2'b01, 2'd1, 32'h0040_0010, 32'hA5A5_0F0F);
        issue(1, 2'b00, 2'd1, 32'h0040_0010, 32'h0);
        idle(3);
        issue(1, 2'b01, 2'd1, 32'h0040_0010, 32'h1234_5678);
        issue(1, 2'b00, 2'd1, 32'h0040_0010, 32'h0);
        idle(3);
        chk("err_addr_clean", err_addr, 0);

        // out-of-range reads and a suppressed write that would alias word 0
        issue(1, 2'b00, 2'd0, 32'h0000_0100, 32'h0);
        idle(3);
        chk("err_addr_set", err_addr, 1);
        issue(1, 2'b01, 2'd3, BASE, 32'h0BAD_F00D);
        issue(1, 2'b01, 2'd3, BASE + MW * 4, 32'hFFFF_FFFF);
        issue(1, 2'b00, 2'd3, BASE, 32'h0);
        issue(1, 2'b00, 2'd0, BASE - 4, 32'h0);
        issue(1, 2'b01, 2'd2, BASE + (MW - 1) * 4 + 3, 32'h7777_1111);
        issue(1, 2'b00, 2'd2, BASE + (MW - 1) * 4, 32'h0);
        issue(1, 2'b00, 2'd1, BASE + MW * 4, 32'h0);
        idle(3);

        // fill words 0..31, then 16 back-to-back reads with rotating threads
        for (int i = 0; i < 32; i++)
            issue(1, 2'b01, 2'(i), BASE + 4 * i, ($urandom & 32'hFFFF_FF00) | 32'(i));
        for (int i = 0; i < 16; i++)
            issue(1, 2'b00, 2'(i), BASE + 4 * ((i * 5) % 32), 32'h0);
        idle(3);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            int          sel;
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = BASE - 4 * $urandom_range(1, 64);
            else if (sel == 1) a = BASE + MW * 4 + 4 * $urandom_range(0, 64);
            else               a = BASE + 4 * $urandom_range(0, 31) + $urandom_range(0, 3);
            issue(1, 2'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(4);
        chk("err_addr_model", err_addr, 32'(err_exp));
        chk("err_addr_still_set", err_addr, 1);

        // reset with requests in flight; the read after release sees pre-reset memory
        issue(1, 2'b00, 2'd3, 32'h0040_0010, 32'h0);
        do_reset(1'b1);
        issue(1, 2'b00, 2'd2, 32'h0040_0010, 32'h0);
        issue(1, 2'b00, 2'd1, BASE + 4 * 7, 32'h0);
        idle(4);
        chk("err_addr_after_rst", err_addr, 0);

`ifdef C2F_RSP_JITTER_EN
        // core ignores stall: expect stall, drops, and in-order survivors
        for (int i = 0; i < 60; i++)
            issue(0, 2'b00, 2'(i), BASE + 4 * (i % 16), 32'h0);
        idle(30);
        for (int i = 0; i < 4; i++)
            issue(1, 2'b00, 2'(i), BASE + 4 * (16 + i), 32'h0);
        idle(30);
        chk("stall_seen", 32'(stall_seen), 1);
        chk("err_drop_set", err_drop, 1);
`endif

        n = 0;
        while (sb.size() > 0 && n < 300) begin
            @(negedge clk);
            req_valid = 1'b0;
            n++;
        end
        chk("queue_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
